// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: default width, opcodes, FSM states
// and the captured command control fields.
package serial_alu_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic       a_inv;
    logic       b_inv;
    logic [1:0] op;
  } ctrl_t;

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: optional operand inversion, then AND / OR / full-add.
module alu_bit_slice
  import serial_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       a_inv,
  input  logic       b_inv,
  input  logic [1:0] op,
  input  logic       cin,
  output logic       out,
  output logic       cout
);

  logic ai;
  logic bi;

  always_comb begin
    ai   = a ^ a_inv;
    bi   = b ^ b_inv;
    out  = 1'b0;
    cout = 1'b0;
    case (op)
      OP_AND:  out = ai & bi;
      OP_OR:   out = ai | bi;
      default: begin
        out  = ai ^ bi ^ cin;
        cout = (ai & bi) | (ai & cin) | (bi & cin);
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: processes one operand bit per clock LSB first through a
// single slice and carry flop, then presents the result with valid/ready.
module serial_alu_seq
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             a_inv,
  input  logic             b_inv,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             msb_cin_q, msb_cin_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic             slice_out_c;
  logic             slice_cout_c;
  logic             ovf_c;
  logic             is_arith_c;
  logic [WIDTH-1:0] final_res_c;

  alu_bit_slice u_slice (
    .a     (a_q[cnt_q]),
    .b     (b_q[cnt_q]),
    .a_inv (ctrl_q.a_inv),
    .b_inv (ctrl_q.b_inv),
    .op    (ctrl_q.op),
    .cin   (carry_q),
    .out   (slice_out_c),
    .cout  (slice_cout_c)
  );

  // Final flags: carry register holds MSB carry-out once RUN completes.
  always_comb begin
    is_arith_c  = ctrl_q.op[1];
    ovf_c       = msb_cin_q ^ carry_q;
    final_res_c = sr_q;
    if (ctrl_q.op == OP_SLT) begin
      final_res_c = {{(WIDTH-1){1'b0}}, sr_q[WIDTH-1] ^ ovf_c};
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    msb_cin_d   = msb_cin_q;
    sr_d        = sr_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d          = a_in;
          b_d          = b_in;
          ctrl_d.a_inv = a_inv;
          ctrl_d.b_inv = b_inv;
          ctrl_d.op    = op;
          carry_d      = b_inv;
          cnt_d        = '0;
          sr_d         = '0;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        sr_d    = {slice_out_c, sr_q[WIDTH-1:1]};
        carry_d = slice_cout_c;
        if (cnt_q == CNT_LAST) begin
          msb_cin_d = carry_q;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        // First DONE cycle latches the result; later cycles wait for the consumer.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          result_d    = final_res_c;
          carry_out_d = is_arith_c & carry_q;
          overflow_d  = is_arith_c & ovf_c;
          zero_d      = (final_res_c == '0);
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      msb_cin_q   <= 1'b0;
      sr_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      msb_cin_q   <= msb_cin_d;
      sr_q        <= sr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed, table-driven bench for serial_alu_seq (WIDTH = 8).
module tb_serial_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       a_inv;
  logic       b_inv;
  logic [1:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry_out;
  logic       overflow;
  logic       zero;

  int checks;
  int errors;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ai;
    logic       bi;
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
  } vec_t;

  serial_alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .a_inv     (a_inv),
    .b_inv     (b_inv),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({v.name, " ready_wait"}, 32'(in_ready), 32'd1);
    a_in = v.a; b_in = v.b; a_inv = v.ai; b_inv = v.bi; op = v.op;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({v.name, " in_ready_after_accept"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({v.name, " latency"}, 32'(n), 32'd9);
    chk({v.name, " result"}, 32'(result), 32'(v.res));
    chk({v.name, " carry"}, 32'(carry_out), 32'(v.c));
    chk({v.name, " overflow"}, 32'(overflow), 32'(v.v));
    chk({v.name, " zero"}, 32'(zero), 32'(v.z));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({v.name, " out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({v.name, " in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[9];

  initial begin
    int n;
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; a_inv = 1'b0; b_inv = 1'b0; op = 2'b00;

    vecs[0] = '{"add_3c_05",  2'b10, 8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"sub_05_05",  2'b10, 8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{"add_7f_01",  2'b10, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{"slt_80_01",  2'b11, 8'h80, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{"nand_f0_0f", 2'b01, 8'hF0, 8'h0F, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"and_f0_0f",  2'b00, 8'hF0, 8'h0F, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{"add_ff_01",  2'b10, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{"slt_01_80",  2'b11, 8'h01, 8'h80, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{"slt_03_05",  2'b11, 8'h03, 8'h05, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};

    // Reset state
    #12;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst flags", {29'd0, carry_out, overflow, zero}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst in_ready_after_edge", 32'(in_ready), 32'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Back-pressure in DONE with a competing command on the input
    a_in = 8'h3C; b_in = 8'h05; a_inv = 1'b0; b_inv = 1'b0; op = 2'b10;
    in_valid = 1'b1;
    tick();
    a_in = 8'h11; b_in = 8'h22; op = 2'b01;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("hold latency", 32'(n), 32'd9);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold result", 32'(result), 32'h41);
      chk("hold out_valid", 32'(out_valid), 32'd1);
      chk("hold in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("hold handoff out_valid", 32'(out_valid), 32'd0);
    chk("hold handoff result", 32'(result), 32'h41);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("hold no_second_capture valid", 32'(out_valid), 32'd0);
      chk("hold no_second_capture ready", 32'(in_ready), 32'd1);
    end

    // Reset in the middle of RUN (bit 4)
    a_in = 8'h7F; b_in = 8'h01; op = 2'b10;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", 32'(in_ready), 32'd0);
    chk("midrst result", 32'(result), 32'd0);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst flags", {29'd0, carry_out, overflow, zero}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("midrst in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst in_ready_after_edge", 32'(in_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("midrst no_out_valid", 32'(out_valid), 32'd0);
    end

    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
